// File: rtl/i2s_tdm_pkg.sv
// i2s_tdm_pkg: shared FSM state type and width constants for the I2S/TDM receiver
package i2s_tdm_pkg;
    localparam int MAX_LANES = 4;
    localparam int WORD_W = 32;
    typedef enum logic [1:0] {IDLE, WAIT_FS, RX} rx_state_t;
endpackage

// File: rtl/i2s_tdm_rx_fifo.sv
// i2s_tdm_rx_fifo: tagged-word FIFO with push/pop, flush and full/empty status
module i2s_tdm_rx_fifo
    import i2s_tdm_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int SW = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [WORD_W-1:0] push_data_i,
    input  logic [SW-1:0]     push_slot_i,
    input  logic [1:0]        push_lane_i,
    input  logic              pop_i,
    output logic [WORD_W-1:0] data_o,
    output logic [SW-1:0]     slot_o,
    output logic [1:0]        lane_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WORD_W-1:0] mem_data [DEPTH];
    logic [SW-1:0]     mem_slot [DEPTH];
    logic [1:0]        mem_lane [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       cnt;
    logic              wr_ok, rd_ok;
    assign empty_o = cnt == '0;
    assign full_o  = cnt == (AW+1)'(DEPTH);
    assign rd_ok   = pop_i && !empty_o;
    assign wr_ok   = push_i && !flush_i && (!full_o || rd_ok);
    assign data_o  = empty_o ? '0 : mem_data[rd_ptr];
    assign slot_o  = empty_o ? '0 : mem_slot[rd_ptr];
    assign lane_o  = empty_o ? '0 : mem_lane[rd_ptr];
    // storage is unreset; the head is masked to zero while empty
    always_ff @(posedge clk_i)
        if (wr_ok) begin
            mem_data[wr_ptr] <= push_data_i;
            mem_slot[wr_ptr] <= push_slot_i;
            mem_lane[wr_ptr] <= push_lane_i;
        end
    // pointers wrap naturally at the power-of-two depth; count tracks occupancy
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
        end
endmodule

// File: rtl/i2s_tdm_rx.sv
// i2s_tdm_rx: multi-lane I2S/TDM receiver into a tagged FIFO; I2S_TDM_RX_PACK16_EN adds 16-bit pair packing
module i2s_tdm_rx
    import i2s_tdm_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int MAX_SLOTS = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cfg_en_i,
    input  logic [$clog2(MAX_SLOTS)-1:0] cfg_slots_i,
    input  logic [4:0]                   cfg_wlen_i,
    input  logic                         cfg_delay_i,
    input  logic                         cfg_lsb_first_i,
    input  logic [MAX_SLOTS-1:0]         cfg_slot_mask_i,
`ifdef I2S_TDM_RX_PACK16_EN
    input  logic                         cfg_pack16_i,
`endif
    input  logic                         ws_i,
    input  logic [NUM_LANES-1:0]         sd_i,
    output logic [WORD_W-1:0]            fifo_data_o,
    output logic [$clog2(MAX_SLOTS)-1:0] fifo_slot_o,
    output logic [1:0]                   fifo_lane_o,
    output logic                         fifo_valid_o,
    input  logic                         fifo_ready_i,
    output logic                         ovf_o,
    output logic                         frame_err_o
);
    localparam int SW = $clog2(MAX_SLOTS);
    rx_state_t         state, state_n;
    logic              ws_q, ws_rise, rise_ok, last, err, ovr, do_smp;
    logic [4:0]        bit_cnt, cur_bit;
    logic [SW-1:0]     slot_cnt, cur_slot, done_slot, hold_slot;
    logic [WORD_W-1:0] sh [NUM_LANES];
    logic [WORD_W-1:0] hold [MAX_LANES];
    logic              done_q, busy, push, pop, full, empty;
    logic [1:0]        idx;
    logic [WORD_W-1:0] push_data;
    assign ws_rise = ~ws_q & ws_i;
    assign pop = fifo_valid_o && fifo_ready_i;
    assign fifo_valid_o = !empty;
    // frame timing decode: which bit is sampled this cycle and whether a sync edge restarts the frame
    always_comb begin
        rise_ok  = ws_rise && (state == WAIT_FS || state == RX);
        last     = state == RX && bit_cnt == cfg_wlen_i && slot_cnt == cfg_slots_i;
        err      = state == RX && ws_rise && !last;
        ovr      = rise_ok && !last && !cfg_delay_i;
        do_smp   = ovr || (state == RX && !err);
        cur_bit  = ovr ? '0 : bit_cnt;
        cur_slot = ovr ? '0 : slot_cnt;
    end
    // next state: disable wins, a sync edge enters RX, the last bit of the frame waits for the next edge
    always_comb begin
        state_n = !cfg_en_i ? IDLE : state == IDLE ? WAIT_FS : rise_ok ? RX : last ? WAIT_FS : state;
    end
    // state register
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state <= IDLE;
        else state <= state_n;
    // sync edge register and bit/slot counters
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            ws_q     <= 1'b0;
            bit_cnt  <= '0;
            slot_cnt <= '0;
        end else begin
            ws_q <= ws_i;
            if (!cfg_en_i || state == IDLE) begin
                bit_cnt  <= '0;
                slot_cnt <= '0;
            end else if (rise_ok) begin
                bit_cnt  <= ovr ? 5'd1 : 5'd0;
                slot_cnt <= '0;
            end else if (do_smp) begin
                bit_cnt  <= cur_bit == cfg_wlen_i ? 5'd0 : cur_bit + 5'd1;
                slot_cnt <= cur_bit == cfg_wlen_i ? cur_slot + SW'(1) : cur_slot;
            end
        end
    // per-lane deserialisers; bit 0 of a slot starts a fresh zero-extended word
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            for (int l = 0; l < NUM_LANES; l++) sh[l] <= '0;
        end else if (do_smp) begin
            for (int l = 0; l < NUM_LANES; l++)
                sh[l] <= cfg_lsb_first_i ? ((cur_bit == 5'd0 ? '0 : sh[l]) | (WORD_W'(sd_i[l]) << cur_bit))
                                         : (cur_bit == 5'd0 ? WORD_W'(sd_i[l]) : {sh[l][WORD_W-2:0], sd_i[l]});
        end
    // slot completion: snapshot all lanes one cycle after the last bit, then drain one lane per cycle
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            done_q    <= 1'b0;
            done_slot <= '0;
            hold_slot <= '0;
            busy      <= 1'b0;
            idx       <= '0;
            for (int l = 0; l < MAX_LANES; l++) hold[l] <= '0;
        end else if (!cfg_en_i) begin
            done_q    <= 1'b0;
            done_slot <= '0;
            hold_slot <= '0;
            busy      <= 1'b0;
            idx       <= '0;
            for (int l = 0; l < MAX_LANES; l++) hold[l] <= '0;
        end else begin
            done_q    <= do_smp && cur_bit == cfg_wlen_i && cfg_slot_mask_i[cur_slot];
            done_slot <= cur_slot;
            if (done_q) begin
                for (int l = 0; l < NUM_LANES; l++) hold[l] <= sh[l];
                hold_slot <= done_slot;
                busy      <= 1'b1;
                idx       <= '0;
            end else if (busy) begin
                idx  <= idx + 2'd1;
                busy <= idx != 2'(NUM_LANES - 1);
            end
        end
`ifdef I2S_TDM_RX_PACK16_EN
    logic [15:0]          half [MAX_LANES];
    logic [MAX_LANES-1:0] half_v;
    logic                 pack;
    assign pack      = cfg_pack16_i && cfg_wlen_i <= 5'd15;
    assign push      = busy && (!pack || half_v[idx]);
    assign push_data = pack ? {hold[idx][15:0], half[idx]} : hold[idx];
    // per-lane pending first half; a frame error or disable drops it
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            half_v <= '0;
            for (int l = 0; l < MAX_LANES; l++) half[l] <= '0;
        end else if (!cfg_en_i || err) begin
            half_v <= '0;
        end else if (busy && pack) begin
            half_v[idx] <= !half_v[idx];
            half[idx]   <= hold[idx][15:0];
        end
`else
    assign push      = busy;
    assign push_data = hold[idx];
`endif
    // sticky error flags, cleared by disable
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            ovf_o       <= 1'b0;
            frame_err_o <= 1'b0;
        end else if (!cfg_en_i) begin
            ovf_o       <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            if (err) frame_err_o <= 1'b1;
            if (push && full && !pop) ovf_o <= 1'b1;
        end
    i2s_tdm_rx_fifo #(.DEPTH(FIFO_DEPTH), .SW(SW)) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (!cfg_en_i),
        .push_i      (push),
        .push_data_i (push_data),
        .push_slot_i (hold_slot),
        .push_lane_i (idx),
        .pop_i       (pop),
        .data_o      (fifo_data_o),
        .slot_o      (fifo_slot_o),
        .lane_o      (fifo_lane_o),
        .full_o      (full),
        .empty_o     (empty)
    );
endmodule

// File: doc/i2s_tdm_rx.md
I2S_TDM_RX -- requirements
Module: i2s_tdm_rx

Interface
REQ-001 SHALL have parameter NUM_LANES, default 2, giving the number of serial data lanes (1..4).
REQ-002 SHALL have parameter MAX_SLOTS, default 8, giving the maximum number of TDM slots per frame (2..16).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, giving the number of output FIFO entries (power of 2, at least 2).
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk_i, input, 1 bit: serial bit clock; all sampling happens on its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port cfg_en_i, input, 1 bit: receiver enable.
REQ-008 SHALL have port cfg_slots_i, input, $clog2(MAX_SLOTS) bits: slots per frame minus 1.
REQ-009 SHALL have port cfg_wlen_i, input, 5 bits: bits per slot minus 1, legal range 7..31.
REQ-010 SHALL have port cfg_delay_i, input, 1 bit: 1 = one-bit delay after frame sync (I2S), 0 = no delay.
REQ-011 SHALL have port cfg_lsb_first_i, input, 1 bit: serial bit order.
REQ-012 SHALL have port cfg_slot_mask_i, input, MAX_SLOTS bits: bit s = 1 stores slot s.
REQ-013 SHALL have port ws_i, input, 1 bit: frame sync; a rising edge marks the frame start.
REQ-014 SHALL have port sd_i, input, NUM_LANES bits: serial data, one bit per lane.
REQ-015 SHALL have ports fifo_data_o (32 bits), fifo_slot_o ($clog2(MAX_SLOTS) bits) and fifo_lane_o (2 bits), all outputs: the head word and its tags.
REQ-016 SHALL have port fifo_valid_o, output, and port fifo_ready_i, input: valid/ready handshake on the FIFO head.
REQ-017 SHALL have ports ovf_o and frame_err_o, outputs, 1 bit each: sticky error flags.

Function
REQ-018 SHALL implement the FSM IDLE -> WAIT_FS -> RX; cfg_en_i=1 moves IDLE to WAIT_FS; cfg_en_i=0 in any state returns to IDLE in the next cycle.
REQ-019 SHALL register ws_i and detect a rising edge when ws_q=0 and ws_i=1.
REQ-020 SHALL, on a rising edge while in WAIT_FS, enter RX with slot=0 and bit=0; the first bit is sampled in the same cycle (cfg_delay_i=0) or one cycle later (cfg_delay_i=1).
REQ-021 SHALL, in RX, shift one bit per cycle per lane into that lane's shift register; MSB-first or LSB-first per cfg_lsb_first_i; words are right-aligned and zero-extended to 32 bits.
REQ-022 SHALL treat bit==cfg_wlen_i as the slot end: bit wraps to 0 and slot increments; after slot==cfg_slots_i, the FSM goes to WAIT_FS and ignores sd_i until the next sync edge.
REQ-023 SHALL, on a sync edge seen in RX before the frame ends, discard the partial slot, set frame_err_o, and restart at slot 0 from that edge.
REQ-024 SHALL, at the end of a slot whose mask bit is set, copy all lanes into holding registers and push them to the FIFO in lane order 0..NUM_LANES-1, one per cycle, tagged with lane and slot.
REQ-025 SHALL make a lane-0 word of a slot visible on fifo_valid_o 2 cycles after the edge that sampled its last bit, provided the FIFO was empty.
REQ-026 SHALL accept a push when the FIFO is full only if a pop occurs in the same cycle; otherwise the word is dropped, ovf_o is set, and the following lanes are still attempted.
REQ-027 SHALL pop on fifo_valid_o & fifo_ready_i; fifo_valid_o = not empty; head outputs are stable while valid=1 and ready=0.
REQ-028 SHALL handle simultaneous push and pop with any occupancy without changing the count; read and write pointers wrap modulo FIFO_DEPTH.
REQ-029 SHALL, on cfg_en_i=0, flush the FIFO, clear the holding buffer and clear both sticky flags.

Reset
REQ-030 SHALL, while rst_i is high, asynchronously force: FSM=IDLE, counters=0, FIFO empty, fifo_valid_o=0, fifo_data_o=0, fifo_slot_o=0, fifo_lane_o=0, ovf_o=0, frame_err_o=0, ws_q=0.
REQ-031 SHALL, when rst_i is asserted mid-frame, lose the partial data; after rst_i is released, reception resumes only at the next sync edge.

Configuration
REQ-032 SHALL, with macro I2S_TDM_RX_PACK16_EN defined, add input cfg_pack16_i; when it is 1 and cfg_wlen_i<=15, two consecutive stored words of the same lane form one entry, the first word in [15:0], tagged with the second word's slot; a pending half is discarded on frame_err or disable.
REQ-033 SHALL, without I2S_TDM_RX_PACK16_EN, have no cfg_pack16_i port and no packing logic.

Structure
REQ-034 SHALL place the FSM state enum, MAX_LANES=4 and the 32-bit word width constant in package i2s_tdm_pkg.
REQ-035 SHALL implement the FIFO as sub-module i2s_tdm_rx_fifo (tagged-word storage, push/pop, full/empty).

Verification
REQ-036 SHALL cover: NUM_LANES=2, 4 slots, wlen=15, MSB-first, delay=1, mask=4'hF, lane0 slot s=16'hA5A0+s -> 8 entries in lane/slot order, data correct.
REQ-037 SHALL cover: mask=4'b0101 -> only slots 0 and 2 are stored; the LSB-first variant receives a bit-reversed serial 0x0001 as 0x8000.
REQ-038 SHALL cover: fifo_ready_i=0 with FIFO_DEPTH=4 and 6 words sent -> 4 entries kept, ovf_o=1, order intact.
REQ-039 SHALL cover: a sync edge in the middle of slot 2 -> frame_err_o=1, the partial word is absent, and the next frame is received correctly.
REQ-040 SHALL cover: rst_i pulsed mid-frame -> all outputs are 0 immediately, and the first data word out comes from the next full frame.
